// File: rtl/mac_result_quantizer.sv
// Turns the never-cleared running MAC sum into per-vector int8 results.
// Results pass through ReLU, a rounded right shift and saturation into a small FWFT FIFO.
module mac_result_quantizer #(
  parameter int unsigned VEC_LEN    = 16,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned RELU_EN    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [31:0]                   acc_data_i,
  input  logic                          acc_valid_i,
  input  logic                          clear_i,
  output logic [7:0]                    out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o
);

  localparam int unsigned CntW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0]      CntLast   = CntW'(VEC_LEN - 1);
  localparam logic [CntW-1:0]      CntOne    = CntW'(1);
  localparam logic [PtrW-1:0]      PtrOne    = PtrW'(1);
  localparam logic [PtrW:0]        CountOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]        CountFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic signed [32:0]   Half      = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0]   SatMax    = 33'sd127;
  localparam logic signed [32:0]   SatMin    = -33'sd128;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     last_acc_q, last_acc_d;
  logic [31:0]     diff_q, diff_d;
  logic            s1_v_q, s1_v_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  // Beat counting and dot-product extraction against the vector base.
  always_comb begin
    cnt_d      = cnt_q;
    base_d     = base_q;
    last_acc_d = last_acc_q;
    diff_d     = diff_q;
    s1_v_d     = 1'b0;
    if (acc_valid_i) begin
      last_acc_d = acc_data_i;
    end
    if (clear_i) begin
      cnt_d  = '0;
      base_d = acc_valid_i ? acc_data_i : last_acc_q;
    end else if (acc_valid_i) begin
      if (cnt_q == CntLast) begin
        diff_d = acc_data_i - base_q;
        base_d = acc_data_i;
        cnt_d  = '0;
        s1_v_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  logic signed [31:0] relu_x;
  logic signed [32:0] rounded;
  logic signed [32:0] shifted;
  logic [7:0]         quant;

  always_comb begin
    relu_x  = ((RELU_EN != 0) && diff_q[31]) ? 32'sd0 : $signed(diff_q);
    rounded = {relu_x[31], relu_x} + Half;
    shifted = rounded >>> SHIFT;
    if (shifted > SatMax) begin
      quant = 8'h7f;
    end else if (shifted < SatMin) begin
      quant = 8'h80;
    end else begin
      quant = shifted[7:0];
    end
  end

  logic push, pop, full, push_ok;

  always_comb begin
    push    = s1_v_q;
    full    = (count_q == CountFull);
    pop     = (count_q != '0) && out_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push && (!full || pop);
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push_ok) begin
        mem_d[wr_ptr_q] = quant;
        wr_ptr_d        = wr_ptr_q + PtrOne;
      end else if (push) begin
        overflow_d = 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      base_q     <= '0;
      last_acc_q <= '0;
      diff_q     <= '0;
      s1_v_q     <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      last_acc_q <= last_acc_d;
      diff_q     <= diff_d;
      s1_v_q     <= s1_v_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    out_valid_o  = (count_q != '0);
    out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    fifo_count_o = count_q;
    overflow_o   = overflow_q;
  end

endmodule

// File: tb/tb_mac_result_quantizer.sv
// Bench for mac_result_quantizer: three configurations share one stimulus stream and are
// checked every cycle against a queue-level model, plus directed literal checks.
module tb_mac_result_quantizer;

  localparam int S     = 2;
  localparam int Depth = 4;
  localparam int NI    = 3;  // 0: VEC_LEN=4 ReLU, 1: VEC_LEN=4 no ReLU, 2: VEC_LEN=1 ReLU

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc_valid = 1'b0;
  logic        clear = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] acc_data = '0;

  logic [7:0]  od [NI];
  logic        ov [NI];
  logic [2:0]  oc [NI];
  logic        oo [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_result_quantizer #(
      .VEC_LEN   ((g == 2) ? 1 : 4),
      .SHIFT     (S),
      .RELU_EN   ((g == 1) ? 0 : 1),
      .FIFO_DEPTH(Depth)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .acc_data_i  (acc_data),
      .acc_valid_i (acc_valid),
      .clear_i     (clear),
      .out_data_o  (od[g]),
      .out_valid_o (ov[g]),
      .out_ready_i (ready),
      .fifo_count_o(oc[g]),
      .overflow_o  (oo[g])
    );
  end

  function automatic int vlen(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit relu(input int i);
    return (i != 1);
  endfunction

  // Real-number requantization: floor((x + 2^(S-1)) / 2^S), clamped to int8.
  function automatic int quant(input bit [31:0] d, input bit relu_on);
    longint x, num, den, q;
    x = longint'($signed(d));
    if (relu_on && x < 0) x = 0;
    den = longint'(1) << S;
    num = x + (den / 2);
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  int       m_cnt  [NI];
  bit [31:0] m_base [NI];
  bit [31:0] m_last [NI];
  bit       m_pv   [NI];
  int       m_pval [NI];
  int       m_fifo [NI][Depth];
  int       m_n    [NI];
  bit       m_ovf  [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_base[i] = '0; m_last[i] = '0; m_pv[i] = 0;
      m_pval[i] = 0; m_n[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int n0;
    bit pop;
    n0  = m_n[i];
    pop = (n0 > 0) && ready;
    if (clear) begin
      m_n[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_pv[i] = 0;
      m_base[i] = acc_valid ? acc_data : m_last[i];
      if (acc_valid) m_last[i] = acc_data;
      return;
    end
    if (pop) begin
      for (int k = 0; k < Depth - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
      m_n[i]--;
    end
    if (m_pv[i]) begin
      if (n0 == Depth && !pop) m_ovf[i] = 1;
      else begin
        m_fifo[i][m_n[i]] = m_pval[i];
        m_n[i]++;
      end
    end
    m_pv[i] = 0;
    if (acc_valid) begin
      m_last[i] = acc_data;
      m_cnt[i]++;
      if (m_cnt[i] == vlen(i)) begin
        m_pval[i] = quant(acc_data - m_base[i], relu(i));
        m_pv[i]   = 1;
        m_base[i] = acc_data;
        m_cnt[i]  = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("valid[%0d]", i), int'(ov[i]), (m_n[i] > 0) ? 1 : 0);
        chk($sformatf("data[%0d]", i), int'(od[i]), (m_n[i] > 0) ? (m_fifo[i][0] & 255) : 0);
        chk($sformatf("count[%0d]", i), int'(oc[i]), m_n[i]);
        chk($sformatf("overflow[%0d]", i), int'(oo[i]), int'(m_ovf[i]));
      end
    end
  end

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d);
    acc_valid = 1'b1;
    acc_data  = 32'(d);
    step1();
    acc_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step1();
    rst = 1'b0;
  endtask

  bit [31:0] sum;
  int        mode;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("pin_q40", quant(32'd40, 1), 10);
    chk("pin_q_neg9", quant(32'hFFFF_FFF7, 0), -2);
    chk("pin_q_neg1000", quant(-32'sd1000, 0), -128);
    chk("pin_q_neg40", quant(-32'sd40, 0), -10);

    chk("rst_valid", int'(ov[0]), 0);
    chk("rst_data", int'(od[0]), 0);
    chk("rst_count", int'(oc[0]), 0);
    chk("rst_ovf", int'(oo[0]), 0);

    // Basic vector, saturation, ReLU clamp
    beat(10); beat(20); beat(30); beat(40); step1();
    chk("s1_data", int'(od[0]), 10);
    chk("s1_count", int'(oc[0]), 1);
    beat(50); beat(60); beat(70); beat(1040); step1();
    chk("s2_sat", int'(od[0]), 127);
    beat(1030); beat(1020); beat(1010); beat(1000); step1();
    chk("s2_relu_valid", int'(ov[0]), 1);
    chk("s2_relu_data", int'(od[0]), 0);
    chk("s2_norelu", int'(od[1]), 8'hF6);

    // Negative rounding without ReLU
    do_reset();
    beat(-1); beat(-3); beat(-6); beat(-9); step1();
    chk("s3_neg", int'(od[1]), 8'hFE);
    beat(-100); beat(-200); beat(-300); beat(-1009); step1();
    chk("s3_negsat", int'(od[1]), 8'h80);
    chk("s3_relu", int'(od[0]), 0);

    // Modular wrap of the running sum
    do_reset();
    beat(1); beat(2); beat(3); beat(32'h7FFF_FFF0); step1();
    beat(5); beat(6); beat(7); beat(32'h8000_0010); step1();
    chk("s4_wrap", int'(od[0]), 8);

    // Overflow with stalled consumer, then push+pop while full
    do_reset();
    ready = 1'b0;
    for (int k = 1; k <= 6; k++) beat(4 * k);
    step1();
    chk("s5_count", int'(oc[2]), 4);
    chk("s5_ovf", int'(oo[2]), 1);
    chk("s5_head", int'(od[2]), 1);
    beat(28);
    ready = 1'b1;
    step1();
    ready = 1'b0;
    chk("s5_full_pushpop", int'(oc[2]), 4);

    // Clear absorbs a concurrent beat into the base
    clear = 1'b1; acc_valid = 1'b1; acc_data = 32'd500;
    step1();
    clear = 1'b0; acc_valid = 1'b0;
    chk("s6_count0", int'(oc[0]), 0);
    chk("s6_count2", int'(oc[2]), 0);
    chk("s6_ovf2", int'(oo[2]), 0);
    ready = 1'b1;
    beat(505); beat(510); beat(515); beat(520); step1();
    chk("s6_data", int'(od[0]), 5);

    // Randomized traffic
    sum  = 32'd0;
    mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if ((k % 200) == 0) mode = $urandom_range(0, 2);
      rst   = ($urandom_range(0, 499) == 0);
      clear = ($urandom_range(0, 59) == 0);
      acc_valid = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0) sum = $urandom;
      else sum = sum + 32'($signed($urandom_range(0, 600)) - 300);
      acc_data = acc_valid ? sum : $urandom;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) != 0);
        default: ready = ($urandom_range(0, 7) == 0);
      endcase
      step1();
    end
    rst = 1'b0; clear = 1'b0; acc_valid = 1'b0;
    step1();
    @(negedge clk);
    #1 done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
